// File: rtl/memreq_arbiter_if.sv
// memreq_arbiter_if
//   Bundles every byte-stream port of memreq_arbiter.
//   s0_* / s1_* : request streams from the two requesters (into the arbiter)
//   r0_* / r1_* : response streams back to the two requesters (out of the arbiter)
//   m_*         : request stream towards the memreq command port (out of the arbiter)
//   q_*         : response stream from the memreq response port (into the arbiter)
//   Modport slave is the arbiter's view; modport master is the view of everything
//   around it (requesters plus memreq), as used by a testbench or top-level wrapper.
interface memreq_arbiter_if;

   logic       s0_tvalid;
   logic       s0_tready;
   logic       s0_tkeep;
   logic       s0_tlast;
   logic [7:0] s0_tdata;

   logic       s1_tvalid;
   logic       s1_tready;
   logic       s1_tkeep;
   logic       s1_tlast;
   logic [7:0] s1_tdata;

   logic       r0_tvalid;
   logic       r0_tready;
   logic       r0_tkeep;
   logic       r0_tlast;
   logic [7:0] r0_tdata;

   logic       r1_tvalid;
   logic       r1_tready;
   logic       r1_tkeep;
   logic       r1_tlast;
   logic [7:0] r1_tdata;

   logic       m_tvalid;
   logic       m_tready;
   logic       m_tkeep;
   logic       m_tlast;
   logic [7:0] m_tdata;

   logic       q_tvalid;
   logic       q_tready;
   logic       q_tkeep;
   logic       q_tlast;
   logic [7:0] q_tdata;

   modport slave (
      input  s0_tvalid, s0_tkeep, s0_tlast, s0_tdata,
      output s0_tready,
      input  s1_tvalid, s1_tkeep, s1_tlast, s1_tdata,
      output s1_tready,
      output r0_tvalid, r0_tkeep, r0_tlast, r0_tdata,
      input  r0_tready,
      output r1_tvalid, r1_tkeep, r1_tlast, r1_tdata,
      input  r1_tready,
      output m_tvalid, m_tkeep, m_tlast, m_tdata,
      input  m_tready,
      input  q_tvalid, q_tkeep, q_tlast, q_tdata,
      output q_tready
   );

   modport master (
      output s0_tvalid, s0_tkeep, s0_tlast, s0_tdata,
      input  s0_tready,
      output s1_tvalid, s1_tkeep, s1_tlast, s1_tdata,
      input  s1_tready,
      input  r0_tvalid, r0_tkeep, r0_tlast, r0_tdata,
      output r0_tready,
      input  r1_tvalid, r1_tkeep, r1_tlast, r1_tdata,
      output r1_tready,
      input  m_tvalid, m_tkeep, m_tlast, m_tdata,
      output m_tready,
      output q_tvalid, q_tkeep, q_tlast, q_tdata,
      input  q_tready
   );

endinterface

// File: rtl/memreq_arbiter.sv
// memreq_arbiter
//   Shares the single memreq command port between two requesters. Whole request
//   frames (delimited by tlast) are granted round-robin and forwarded unmodified;
//   the port of every completed frame is pushed into a grant-order FIFO. memreq
//   answers strictly in order, so the FIFO head tells which requester owns the
//   response frame currently on q_*.
//
// Ports
//   bclk      : bus clock, the only clock domain
//   rst       : synchronous active-high reset
//   bus       : all stream ports (memreq_arbiter_if.slave)
//   pending_o : grant-order FIFO occupancy (registered)
//   orphan_o  : one-cycle pulse, the cycle after a response beat arrived with
//               the FIFO empty (that beat was dropped)
//
// PENDING must be a power of two and at least 2 so the pointers wrap naturally.
module memreq_arbiter #(
   parameter int unsigned PENDING = 4
) (
   input  logic                      bclk,
   input  logic                      rst,
   memreq_arbiter_if.slave           bus,
   output logic [$clog2(PENDING):0]  pending_o,
   output logic                      orphan_o
);

   localparam int unsigned PtrW = $clog2(PENDING);
   localparam logic [PtrW:0] CntFull = PENDING[PtrW:0];
   localparam logic [PtrW:0] CntOne  = {{PtrW{1'b0}}, 1'b1};
   localparam logic [PtrW-1:0] PtrOne = {{(PtrW-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {StIdle, StFwd} state_e;

   state_e          state_q, state_d;
   logic            sel_q, sel_d;
   logic            last_q, last_d;
   logic            orphan_q, orphan_d;

   // Grant-order FIFO: one bit per outstanding frame, the requester index.
   logic [PENDING-1:0] route_q;
   logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]      count_q, count_d;

   logic full, empty;
   logic push, pop;
   logic head;

   assign full      = (count_q == CntFull);
   assign empty     = (count_q == '0);
   assign head      = route_q[rd_ptr_q];
   assign pending_o = count_q;
   assign orphan_o  = orphan_q;

   // ---------------------------------------------------------------------------
   // Request side: frame-granular round-robin grant and pass-through.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      last_d        = last_q;
      push          = 1'b0;
      bus.m_tvalid  = 1'b0;
      bus.m_tkeep   = 1'b0;
      bus.m_tlast   = 1'b0;
      bus.m_tdata   = '0;
      bus.s0_tready = 1'b0;
      bus.s1_tready = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A full FIFO only blocks new grants; a frame in flight always has a slot.
            if (!full && (bus.s0_tvalid || bus.s1_tvalid)) begin
               state_d = StFwd;
               if (bus.s0_tvalid && bus.s1_tvalid) begin
                  sel_d = ~last_q;
               end else begin
                  sel_d = bus.s1_tvalid;
               end
            end
         end
         StFwd: begin
            if (sel_q) begin
               bus.m_tvalid  = bus.s1_tvalid;
               bus.m_tkeep   = bus.s1_tkeep;
               bus.m_tlast   = bus.s1_tlast;
               bus.m_tdata   = bus.s1_tdata;
               bus.s1_tready = bus.m_tready;
            end else begin
               bus.m_tvalid  = bus.s0_tvalid;
               bus.m_tkeep   = bus.s0_tkeep;
               bus.m_tlast   = bus.s0_tlast;
               bus.m_tdata   = bus.s0_tdata;
               bus.s0_tready = bus.m_tready;
            end
            if (bus.m_tvalid && bus.m_tready && bus.m_tlast) begin
               push    = 1'b1;
               last_d  = sel_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Response side: route q_* by the FIFO head, drop beats nobody asked for.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.r0_tvalid = 1'b0;
      bus.r0_tkeep  = bus.q_tkeep;
      bus.r0_tlast  = bus.q_tlast;
      bus.r0_tdata  = bus.q_tdata;
      bus.r1_tvalid = 1'b0;
      bus.r1_tkeep  = bus.q_tkeep;
      bus.r1_tlast  = bus.q_tlast;
      bus.r1_tdata  = bus.q_tdata;
      bus.q_tready  = 1'b0;
      pop           = 1'b0;
      orphan_d      = 1'b0;

      if (empty) begin
         // Sink orphans, but keep every ready low while reset is held.
         bus.q_tready = ~rst;
         orphan_d     = bus.q_tvalid;
      end else begin
         if (head) begin
            bus.r1_tvalid = bus.q_tvalid;
            bus.q_tready  = bus.r1_tready;
         end else begin
            bus.r0_tvalid = bus.q_tvalid;
            bus.q_tready  = bus.r0_tready;
         end
         pop = bus.q_tvalid && bus.q_tready && bus.q_tlast;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntOne;
      end else if (pop && !push) begin
         count_d = count_q - CntOne;
      end
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   always_ff @(posedge bclk) begin
      if (rst) begin
         state_q  <= StIdle;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;
         orphan_q <= 1'b0;
         route_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         orphan_q <= orphan_d;
         count_q  <= count_d;
         if (push) begin
            route_q[wr_ptr_q] <= sel_q;
            wr_ptr_q          <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
      end
   end

endmodule
